// File: rtl/inst_config_serializer_pkg.sv
// Shared instruction-word and config-frame layout for the CGRA instruction path.
// The PE-side field decoder uses the same constants, so both sides agree on bit positions.
package inst_config_serializer_pkg;

  localparam int INST_SIZE = 32;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int IMM_MSB  = 25;
  localparam int IMM_LSB  = 12;
  localparam int ARG0_MSB = 11;
  localparam int ARG0_LSB = 9;
  localparam int ARG1_MSB = 8;
  localparam int ARG1_LSB = 6;
  localparam int ARG2_MSB = 5;
  localparam int ARG2_LSB = 3;
  localparam int ARG3_MSB = 2;
  localparam int ARG3_LSB = 0;

  localparam int HDR_W        = 16;
  localparam int HDR_LAST_BIT = 15;
  localparam int HDR_PE_MSB   = 14;
  localparam int HDR_PE_LSB   = 9;
  localparam int HDR_SLOT_MSB = 8;
  localparam int HDR_SLOT_LSB = 5;

  localparam int FRAME_W = HDR_W + INST_SIZE;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Low header bits stay zero; they are reserved for the loader.
  function automatic logic [HDR_W-1:0] pack_header(
    input logic                             last,
    input logic [HDR_PE_MSB-HDR_PE_LSB:0]   pe_id,
    input logic [HDR_SLOT_MSB-HDR_SLOT_LSB:0] slot
  );
    logic [HDR_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_LAST_BIT]              = last;
    hdr[HDR_PE_MSB:HDR_PE_LSB]     = pe_id;
    hdr[HDR_SLOT_MSB:HDR_SLOT_LSB] = slot;
    return hdr;
  endfunction

endpackage

// File: rtl/inst_field_packer.sv
// Combinational packer: decoded instruction fields in, one instruction word out.
// Exact inverse of the PE-side field decoder.
module inst_field_packer
  import inst_config_serializer_pkg::*;
(
  input  logic [OP_MSB-OP_LSB:0]     i_op,
  input  logic [IMM_MSB-IMM_LSB:0]   i_imm,
  input  logic [ARG0_MSB-ARG0_LSB:0] i_arg0,
  input  logic [ARG1_MSB-ARG1_LSB:0] i_arg1,
  input  logic [ARG2_MSB-ARG2_LSB:0] i_arg2,
  input  logic [ARG3_MSB-ARG3_LSB:0] i_arg3,
  output logic [INST_SIZE-1:0]       o_inst
);

  always_comb begin
    o_inst = '0;
    o_inst[OP_MSB:OP_LSB]     = i_op;
    o_inst[IMM_MSB:IMM_LSB]   = i_imm;
    o_inst[ARG0_MSB:ARG0_LSB] = i_arg0;
    o_inst[ARG1_MSB:ARG1_LSB] = i_arg1;
    o_inst[ARG2_MSB:ARG2_LSB] = i_arg2;
    o_inst[ARG3_MSB:ARG3_LSB] = i_arg3;
  end

endmodule

// File: rtl/inst_config_serializer.sv
// Packs an instruction tuple, prefixes a routing header and streams the 48-bit frame
// MSB-first over a CFG_W-wide valid/ready config bus with back-to-back frame support.
module inst_config_serializer #(
  parameter int INST_SIZE = 32,
  parameter int CFG_W     = 8,
  parameter int PE_ID_W   = 6,
  parameter int SLOT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         op,
  input  logic [13:0]        imm,
  input  logic [2:0]         arg0,
  input  logic [2:0]         arg1,
  input  logic [2:0]         arg2,
  input  logic [2:0]         arg3,
  input  logic [PE_ID_W-1:0] pe_id,
  input  logic [SLOT_W-1:0]  slot,
  input  logic               last,
  output logic               cfg_valid,
  input  logic               cfg_ready,
  output logic [CFG_W-1:0]   cfg_data,
  output logic               cfg_sof,
  output logic               cfg_eof,
  output logic               prog_done,
  output logic [7:0]         inst_count
);

  import inst_config_serializer_pkg::*;

  localparam int BEATS = FRAME_W / CFG_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t             r_state;
  logic [FRAME_W-1:0] r_shreg;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic               r_last;
  logic [7:0]         r_inst_count;
  logic               r_prog_done;

  logic [INST_SIZE-1:0] w_inst;
  logic [FRAME_W-1:0]   w_frame;
  logic                 w_send;
  logic                 w_at_eof;
  logic                 w_beat_hs;
  logic                 w_frame_done;
  logic                 w_accept;

  inst_field_packer u_packer (
    .i_op   (op),
    .i_imm  (imm),
    .i_arg0 (arg0),
    .i_arg1 (arg1),
    .i_arg2 (arg2),
    .i_arg3 (arg3),
    .o_inst (w_inst)
  );

  assign w_frame      = {pack_header(last, pe_id, slot), w_inst};
  assign w_send       = (r_state == SEND);
  assign w_at_eof     = w_send && (r_beat_cnt == LAST_BEAT);
  assign w_beat_hs    = w_send && cfg_ready;
  assign w_frame_done = w_at_eof && cfg_ready;
  // Accepting on the eof handshake keeps the bus busy every cycle across frames.
  assign in_ready     = (r_state == IDLE) || w_frame_done;
  assign w_accept     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_beat_cnt   <= '0;
      r_last       <= 1'b0;
      r_inst_count <= 8'd0;
      r_prog_done  <= 1'b0;
    end else begin
      r_prog_done <= 1'b0;
      if (w_frame_done) begin
        if (r_last) begin
          r_inst_count <= 8'd0;
          r_prog_done  <= 1'b1;
        end else if (r_inst_count != 8'hFF) begin
          r_inst_count <= r_inst_count + 8'd1;
        end
      end

      if (w_accept) begin
        r_state    <= SEND;
        r_shreg    <= w_frame;
        r_beat_cnt <= '0;
        r_last     <= last;
      end else if (w_beat_hs) begin
        // After the final shift the register is all zero, so cfg_data reads 0 in IDLE.
        r_shreg    <= r_shreg << CFG_W;
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        if (w_frame_done) begin
          r_state <= IDLE;
        end
      end
    end
  end

  assign cfg_valid  = w_send;
  assign cfg_data   = r_shreg[FRAME_W-1 -: CFG_W];
  assign cfg_sof    = w_send && (r_beat_cnt == '0);
  assign cfg_eof    = w_at_eof;
  assign prog_done  = r_prog_done;
  assign inst_count = r_inst_count;

endmodule

// File: doc/inst_config_serializer.md
Name: inst_config_serializer

Overview:
Transmit side of the CGRA instruction path. It takes decoded instruction fields (op, imm, arg0..arg3) plus a PE target and slot, and packs them into an INST_SIZE-bit instruction word. The field layout is the exact inverse of the PE-side field decoder. Each packed instruction is prefixed with a routing header and sent MSB-first over a narrow valid/ready configuration bus to the PE array loader.

Parameters:
INST_SIZE, 32, instruction word width; fixed field layout requires 32.
CFG_W, 8, config bus beat width; must divide 16 and 32, so legal values are 1, 2, 4, 8, 16.
PE_ID_W, 6, PE identifier width; fixed by the header layout.
SLOT_W, 4, instruction slot index width; fixed by the header layout.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  field tuple valid
in_ready  out  1  tuple accepted when in_valid && in_ready
op  in  6  opcode
imm  in  14  immediate, raw bits
arg0  in  3  argument 0
arg1  in  3  argument 1
arg2  in  3  argument 2
arg3  in  3  argument 3
pe_id  in  PE_ID_W  target PE
slot  in  SLOT_W  target instruction slot
last  in  1  final instruction of the program
cfg_valid  out  1  beat valid
cfg_ready  in  1  beat accepted when cfg_valid && cfg_ready
cfg_data  out  CFG_W  beat payload
cfg_sof  out  1  high on the first beat of a frame
cfg_eof  out  1  high on the last beat of a frame
prog_done  out  1  one-cycle pulse when a frame with last=1 completes
inst_count  out  8  frames completed in the current program

Behaviour:
- Packing: inst = {op[31:26], imm[25:12], arg0[11:9], arg1[8:6], arg2[5:3], arg3[2:0]}.
- Header is 16 bits: {last[15], pe_id[14:9], slot[8:5], 5'b0}.
- Frame is {header, inst}, 48 bits, sent MSB-first. BEATS = 48/CFG_W.
- States:
  - IDLE: cfg_valid=0 and in_ready=1. On an accepted tuple, load the 48-bit shift register, set beat_cnt=0 and go to SEND.
  - SEND: cfg_valid=1 and cfg_data = shreg[47 -: CFG_W].
- On a SEND handshake: shift shreg left by CFG_W and increment beat_cnt.
- On the handshake where beat_cnt==BEATS-1, the frame completes:
  - If in_valid is high in that cycle, accept the next tuple (reload, stay in SEND).
  - Otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==SEND && beat_cnt==BEATS-1 && cfg_ready). This is the only combinational in-to-out path and gives full back-to-back throughput.
- Latency: a tuple accepted in cycle N produces its first beat with cfg_valid=1 in cycle N+1.
- cfg_sof = SEND && beat_cnt==0. cfg_eof = SEND && beat_cnt==BEATS-1.
- While cfg_valid=1 and cfg_ready=0, cfg_data, cfg_sof and cfg_eof hold stable. cfg_valid never drops before its handshake.
- Frame completion updates:
  - inst_count increments, saturating at 255.
  - If the completed frame had last=1: prog_done pulses in the next cycle and inst_count clears to 0 instead of incrementing.
  - The last flag is captured at accept time and held for the whole frame.
- Reset (synchronous, also mid-frame):
  - State goes to IDLE; shreg, beat_cnt and inst_count go to 0.
  - cfg_valid, cfg_sof, cfg_eof and prog_done are 0 after the reset edge.
  - A partial frame is dropped, never resumed.
- cfg_data is 0 in IDLE and after reset.
- Input fields are sampled only on accept; changes while in_ready=0 are ignored.

Decomposition:
- Shared package (also used by the PE-side decoder):
  - INST_SIZE.
  - Field MSB/LSB constants for op, imm and arg0..arg3.
  - HDR_W=16 and the header bit positions.
  - State encoding: IDLE, SEND.
- One sub-module, inst_field_packer: purely combinational, fields in and INST_SIZE word out. It is reused by the assembler-side testbench models.

Test Plan:
1. CFG_W=8, cfg_ready held high; op=6'h2A, imm=14'h1234, arg0..3=1,2,3,4, pe_id=5, slot=3, last=0. Expected: beats 0x0A, 0x60, 0xA9, 0x23, 0x42, 0x9C in 6 consecutive cycles starting 1 cycle after accept; sof on 0x0A, eof on 0x9C; inst_count=1.
2. Same tuple, cfg_ready low for 3 cycles at beat 1. Expected: cfg_data holds 0x60 with cfg_valid=1 throughout; 6 beats total, no duplicate or skip.
3. Two tuples back-to-back with in_valid and cfg_ready always high. Expected: 12 beats in 12 cycles with no bubble; in_ready high only in IDLE and on eof-handshake cycles.
4. Three frames, the third with last=1. Expected: prog_done pulses once in the cycle after the third eof; inst_count reads 1, 2, then 0.
5. rst asserted for one cycle at beat 3 of a frame. Expected: cfg_valid=0 the next cycle and in_ready=1; the next tuple starts a fresh frame with sof.
6. CFG_W=16 build, test 1 tuple. Expected: beats 0x0A60, 0xA923, 0x429C; sof on the first, eof on the third.
